// File: rtl/camera_pattern_gen_pkg.sv
// camera_pattern_gen_pkg
// Shared definitions for the camera test-pattern transmitter: frame FSM
// state encoding, pixel/counter widths, the marker register layout and the
// line-period derivation used by both the top level and the line timer.
package camera_pattern_gen_pkg;

    localparam int PIX_W = 8;   // width of every colour channel and of x/y
    localparam int CNT_W = 24;  // wide enough for several 256-pixel line periods

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    // Marker position and colour, captured once per frame.
    typedef struct packed {
        logic [PIX_W-1:0] x;
        logic [PIX_W-1:0] y;
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } marker_t;

    // Clocks in one full line: active pixels plus horizontal blanking.
    function automatic int line_clks(input int h_active, input int pix_div,
                                     input int h_blank);
        return h_active * pix_div + h_blank;
    endfunction

endpackage

// File: rtl/camera_line_timer.sv
// camera_line_timer
// Horizontal timing for one active line: counts clocks within the line,
// clocks within a pixel and the pixel column, and produces registered
// href / pixelReady / endOfLine.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   lineRun      high while the next cycle belongs to the active region
//   href         high during the active part of the line
//   pixelReady   one-clock strobe on the last clock of each pixel
//   endOfLine    high on the last clock of each line period
//   hrefNext     value href takes after the next edge (for aligned data regs)
//   xNext        pixel column for the next cycle (for aligned data regs)
module camera_line_timer
    import camera_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE = 160,
    parameter int H_BLANK  = 16,
    parameter int PIX_DIV  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lineRun,
    output logic             href,
    output logic             pixelReady,
    output logic             endOfLine,
    output logic             hrefNext,
    output logic [PIX_W-1:0] xNext
);

    localparam logic [CNT_W-1:0] HACT_CLKS = CNT_W'(H_ACTIVE * PIX_DIV);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(line_clks(H_ACTIVE, PIX_DIV, H_BLANK) - 1);
    localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(PIX_DIV - 1);

    logic             run_q;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] pix_q, pix_d;
    logic [PIX_W-1:0] x_q, x_d;
    logic             href_q, href_d;
    logic             ready_q, ready_d;
    logic             eol_q, eol_d;

    // The counters describe the position of the *next* cycle, so the output
    // flops are loaded from the _d values and line up with the counters.
    always_comb begin
        h_cnt_d = '0;
        pix_d   = '0;
        x_d     = '0;
        // Continue the current line; a fresh run or a wrap restarts at 0.
        if (lineRun && run_q && (h_cnt_q != LINE_LAST)) begin
            h_cnt_d = h_cnt_q + 1'b1;
            pix_d   = pix_q;
            x_d     = x_q;
            if (h_cnt_d < HACT_CLKS) begin
                if (pix_q == PIX_LAST) begin
                    pix_d = '0;
                    x_d   = x_q + 1'b1;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
        end
        href_d  = lineRun && (h_cnt_d < HACT_CLKS);
        ready_d = href_d && (pix_d == PIX_LAST);
        eol_d   = lineRun && (h_cnt_d == LINE_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q   <= 1'b0;
            h_cnt_q <= '0;
            pix_q   <= '0;
            x_q     <= '0;
            href_q  <= 1'b0;
            ready_q <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            run_q   <= lineRun;
            h_cnt_q <= h_cnt_d;
            pix_q   <= pix_d;
            x_q     <= x_d;
            href_q  <= href_d;
            ready_q <= ready_d;
            eol_q   <= eol_d;
        end
    end

    assign href       = href_q;
    assign pixelReady = ready_q;
    assign endOfLine  = eol_q;
    assign hrefNext   = href_d;
    assign xNext      = x_d;

endmodule

// File: rtl/camera_pattern_gen.sv
// camera_pattern_gen
// Camera-interface transmitter: generates vsync/href/pixelReady timing and
// a gradient frame (R = column, G = line, B = 0) with one programmable
// marker pixel. Marker inputs are captured when a frame starts.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   enable                run frames while high (current frame always completes)
//   markerX/Y             marker position
//   markerRed/Green/Blue  marker colour
//   vsync, href           frame and line sync
//   pixelReady            one-clock strobe per pixel, data valid
//   outRed/Green/Blue     pixel data, zero outside href
//   frameCount            completed frames, wraps at 256
module camera_pattern_gen
    import camera_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE    = 160,
    parameter int V_ACTIVE    = 120,
    parameter int H_BLANK     = 16,
    parameter int PIX_DIV     = 2,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [PIX_W-1:0] markerX,
    input  logic [PIX_W-1:0] markerY,
    input  logic [PIX_W-1:0] markerRed,
    input  logic [PIX_W-1:0] markerGreen,
    input  logic [PIX_W-1:0] markerBlue,
    output logic             vsync,
    output logic             href,
    output logic             pixelReady,
    output logic [PIX_W-1:0] outRed,
    output logic [PIX_W-1:0] outGreen,
    output logic [PIX_W-1:0] outBlue,
    output logic [PIX_W-1:0] frameCount
);

    localparam int LINE_CLKS = line_clks(H_ACTIVE, PIX_DIV, H_BLANK);
    localparam int VS_CLKS   = VSYNC_LINES * LINE_CLKS;
    localparam int VB_CLKS   = V_BACK * LINE_CLKS;
    localparam int VF_CLKS   = V_FRONT * LINE_CLKS;

    localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(VS_CLKS - 1);
    localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(VB_CLKS - 1);
    localparam logic [CNT_W-1:0] VF_LAST = CNT_W'(VF_CLKS - 1);
    localparam logic [PIX_W-1:0] Y_LAST  = PIX_W'(V_ACTIVE - 1);

    // Zero-length vertical states are skipped by jumping past them.
    localparam state_t AFTER_VSYNC = (VB_CLKS > 0) ? ST_VBACK : ST_ACTIVE;
    localparam state_t FRAME_START = (VS_CLKS > 0) ? ST_VSYNC : AFTER_VSYNC;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0] y_q, y_d;
    logic [PIX_W-1:0] frame_q, frame_d;
    marker_t          marker_q, marker_d;
    logic             vsync_q, vsync_d;
    logic [PIX_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic             frame_end;
    logic             start;

    logic             line_run;
    logic             end_of_line;
    logic             href_next;
    logic [PIX_W-1:0] x_next;

    // Frame FSM: next state, vertical counters and marker capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        y_d       = y_q;
        frame_d   = frame_q;
        marker_d  = marker_q;
        frame_end = 1'b0;
        start     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                start = enable;
            end
            ST_VSYNC: begin
                if (cnt_q == VS_LAST) begin
                    state_d = AFTER_VSYNC;
                    cnt_d   = '0;
                end
            end
            ST_VBACK: begin
                if (cnt_q == VB_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end
            end
            ST_ACTIVE: begin
                cnt_d = '0;
                if (end_of_line) begin
                    y_d = y_q + 1'b1;
                    if (y_q == Y_LAST) begin
                        if (VF_CLKS > 0) begin
                            state_d = ST_VFRONT;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end
                end
            end
            ST_VFRONT: begin
                if (cnt_q == VF_LAST) begin
                    frame_end = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Last cycle of the frame: count it, then restart or park in IDLE.
        if (frame_end) begin
            frame_d = frame_q + 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
            start   = enable;
        end
        if (start) begin
            state_d  = FRAME_START;
            cnt_d    = '0;
            marker_d = {markerX, markerY, markerRed, markerGreen, markerBlue};
        end
        if ((state_d != ST_ACTIVE) || frame_end) begin
            y_d = '0;
        end
        vsync_d = (state_d == ST_VSYNC);
    end

    // The line timer is told one cycle ahead so its registered outputs line
    // up with the registered vsync and pixel data.
    assign line_run = (state_d == ST_ACTIVE);

    camera_line_timer #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .PIX_DIV  (PIX_DIV)
    ) u_line_timer (
        .clk        (clk),
        .reset      (reset),
        .lineRun    (line_run),
        .href       (href),
        .pixelReady (pixelReady),
        .endOfLine  (end_of_line),
        .hrefNext   (href_next),
        .xNext      (x_next)
    );

    // Pixel data for the next cycle; held for the whole pixel because
    // x_next only moves when the pixel divider wraps.
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (href_next) begin
            if ((x_next == marker_d.x) && (y_d == marker_d.y)) begin
                red_d   = marker_d.r;
                green_d = marker_d.g;
                blue_d  = marker_d.b;
            end else begin
                red_d   = x_next;
                green_d = y_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            y_q      <= '0;
            frame_q  <= '0;
            marker_q <= '0;
            vsync_q  <= 1'b0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            frame_q  <= frame_d;
            marker_q <= marker_d;
            vsync_q  <= vsync_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
        end
    end

    assign vsync      = vsync_q;
    assign outRed     = red_q;
    assign outGreen   = green_q;
    assign outBlue    = blue_q;
    assign frameCount = frame_q;

endmodule

// File: tb/tb_camera_pattern_gen.sv
// tb_camera_pattern_gen
// Scoreboard bench for camera_pattern_gen with a small frame geometry
// (4x3 active, 2 blank clocks, 1 line each of vsync/back/front porch, so a
// line is 10 clocks and a frame 60). Stimulus pushes the expected pixel
// stream; a monitor pops on every pixelReady. A second monitor checks
// frame/line timing. A second instance with one clock per pixel checks
// that pixelReady follows href.
module tb_camera_pattern_gen;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] markerX = 8'd2, markerY = 8'd1;
    logic [7:0] markerRed = 8'd200, markerGreen = 8'd10, markerBlue = 8'd30;

    logic       vsync, href, pixelReady;
    logic [7:0] outRed, outGreen, outBlue, frameCount;
    logic       vsync1, href1, pixelReady1;
    logic [7:0] outRed1, outGreen1, outBlue1, frameCount1;

    int   checks = 0;
    int   errors = 0;
    pix_t exp_q[$];
    bit   have_prev_vs = 1'b0;
    bit   log_pixels = 1'b1;
    int   pix_n = 0;

    always #5 clk = ~clk;

    camera_pattern_gen #(
        .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .PIX_DIV(2),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .markerX(markerX), .markerY(markerY),
        .markerRed(markerRed), .markerGreen(markerGreen), .markerBlue(markerBlue),
        .vsync(vsync), .href(href), .pixelReady(pixelReady),
        .outRed(outRed), .outGreen(outGreen), .outBlue(outBlue),
        .frameCount(frameCount)
    );

    camera_pattern_gen #(
        .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .PIX_DIV(1),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut_pd1 (
        .clk(clk), .reset(reset), .enable(enable),
        .markerX(markerX), .markerY(markerY),
        .markerRed(markerRed), .markerGreen(markerGreen), .markerBlue(markerBlue),
        .vsync(vsync1), .href(href1), .pixelReady(pixelReady1),
        .outRed(outRed1), .outGreen(outGreen1), .outBlue(outBlue1),
        .frameCount(frameCount1)
    );

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Expected pixel stream of one 4x3 frame for the given marker.
    task automatic push_frame(input int mx, input int my, input int mr, input int mg, input int mb);
        pix_t p;
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                if (x == mx && y == my) p = {8'(mr), 8'(mg), 8'(mb)};
                else                    p = {8'(x), 8'(y), 8'd0};
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic wait_href(input logic level, input string tag);
        int n;
        n = 0;
        while (href !== level && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (href !== level) check(1'b0, tag, int'(href), int'(level));
    endtask

    task automatic wait_fc(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (frameCount != 8'(target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frameCount != 8'(target)) check(1'b0, tag, int'(frameCount), target);
    endtask

    task automatic check_all_zero(input string tag);
        check({vsync, href, pixelReady, outRed, outGreen, outBlue} == 27'd0, {tag, "_outs"},
              int'({vsync, href, pixelReady, outRed, outGreen, outBlue}), 0);
        check(frameCount == 8'd0, {tag, "_frame_count"}, int'(frameCount), 0);
        check({vsync1, href1, pixelReady1, outRed1, outGreen1, outBlue1, frameCount1} == 35'd0,
              {tag, "_pd1_outs"}, int'({href1, outRed1, frameCount1}), 0);
    endtask

    // Scoreboard monitor: one pop per pixelReady sample.
    initial begin : pixel_mon
        pix_t e;
        forever begin
            @(negedge clk);
            if (!reset && pixelReady) begin
                pix_n++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "pixel_unexpected", int'({outRed, outGreen, outBlue}), 0);
                end else begin
                    e = exp_q.pop_front();
                    check({outRed, outGreen, outBlue} == e, "pixel_data",
                          int'({outRed, outGreen, outBlue}), int'(e));
                    if (log_pixels)
                        $display("pixel %0d: rgb=(%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                                 pix_n, outRed, outGreen, outBlue, e.r, e.g, e.b);
                end
            end
        end
    end

    // Timing monitor: vsync width, frame period, porch, href width, hblank,
    // pixelReady phase, data hold within a pixel, quiet outputs outside href.
    initial begin : timing_mon
        int   vs_len, href_len, low_len, cyc, last_rise;
        logic vs_p, hr_p;
        bit   first_line;
        logic [23:0] held;
        vs_len = 0; href_len = 0; low_len = 0; cyc = 0; last_rise = 0;
        vs_p = 1'b0; hr_p = 1'b0; first_line = 1'b0; held = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                vs_len = 0; href_len = 0; low_len = 0;
                vs_p = 1'b0; hr_p = 1'b0; first_line = 1'b0;
                have_prev_vs = 1'b0;
            end else begin
                if (vsync && !vs_p) begin
                    if (have_prev_vs) check(cyc - last_rise == 60, "frame_period", cyc - last_rise, 60);
                    have_prev_vs = 1'b1;
                    last_rise = cyc;
                end
                if (vsync) vs_len++;
                if (!vsync && vs_p) begin
                    check(vs_len == 10, "vsync_len", vs_len, 10);
                    vs_len = 0;
                    first_line = 1'b1;
                    low_len = 0;
                end
                if (href && !hr_p) begin
                    if (first_line) check(low_len == 10, "vsync_to_href", low_len, 10);
                    else            check(low_len == 2, "hblank_len", low_len, 2);
                    first_line = 1'b0;
                    href_len = 0;
                end
                if (!href && hr_p) begin
                    check(href_len == 8, "href_len", href_len, 8);
                    low_len = 0;
                end
                if (href) begin
                    check(int'(pixelReady) == (href_len % 2), "ready_phase", int'(pixelReady), href_len % 2);
                    if (href_len % 2 == 0) held = {outRed, outGreen, outBlue};
                    else check({outRed, outGreen, outBlue} == held, "pixel_hold",
                               int'({outRed, outGreen, outBlue}), int'(held));
                    href_len++;
                end else begin
                    check(!pixelReady && ({outRed, outGreen, outBlue} == 24'd0), "blank_out",
                          int'({pixelReady, outRed, outGreen, outBlue}), 0);
                    low_len++;
                end
                check(pixelReady1 == href1, "pd1_ready_eq_href", int'(pixelReady1), int'(href1));
                vs_p = vsync;
                hr_p = href;
            end
        end
    end

    initial begin : stimulus
        int bad;
        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2 reset = 1'b0;
        @(negedge clk);
        check(vsync == 1'b0, "idle_vsync", int'(vsync), 0);

        // Frame 0: marker (2,1) colour (200,10,30); vsync the cycle after enable.
        push_frame(2, 1, 200, 10, 30);
        enable = 1'b1;
        @(negedge clk);
        check(vsync == 1'b1, "vsync_start", int'(vsync), 1);

        // Mid-frame marker change only affects the next frame.
        wait_href(1'b1, "href_line0_timeout");
        markerX = 8'd0;
        push_frame(0, 1, 200, 10, 30);

        // Drop enable during frame 1: it completes, then the generator idles.
        wait_fc(1, 200, "frame0_done_timeout");
        wait_href(1'b1, "href_frame1_timeout");
        enable = 1'b0;
        wait_fc(2, 200, "frame1_done_timeout");
        check(exp_q.size() == 0, "frames01_all_pixels", exp_q.size(), 0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (vsync || href) bad++;
        end
        check(bad == 0, "idle_quiet", bad, 0);
        check(frameCount == 8'd2, "frame_count_idle", int'(frameCount), 2);

        // Re-enable with the marker outside the active area.
        markerX = 8'd9; markerY = 8'd0;
        push_frame(9, 0, 200, 10, 30);
        have_prev_vs = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        check(vsync == 1'b1, "vsync_reenable", int'(vsync), 1);

        // Asynchronous reset in the middle of a line.
        wait_href(1'b1, "href_frame2_timeout");
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        exp_q.delete();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        // 256 frames back to back: frameCount wraps to 0.
        log_pixels = 1'b0;
        for (int f = 0; f < 256; f++) push_frame(9, 0, 200, 10, 30);
        @(negedge clk);
        enable = 1'b1;
        wait_fc(255, 20000, "frame255_timeout");
        enable = 1'b0;
        wait_fc(0, 200, "frame_wrap_timeout");
        check(exp_q.size() == 0, "wrap_all_pixels", exp_q.size(), 0);
        repeat (20) @(negedge clk);
        check(frameCount == 8'd0, "frame_count_wrapped", int'(frameCount), 0);
        check(vsync == 1'b0 && href == 1'b0, "idle_after_wrap", int'({vsync, href}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/camera_pattern_gen.md
Name: camera_pattern_gen

Overview:
- Transmitter side of the camera pixel interface: generates vsync, href and pixelReady timing plus 8-bit RGB pixel data.
- Drives the colour tracker's inputs in simulation and on-board bring-up in place of the real sensor.
- Frame content is a gradient background with one programmable marker pixel, so the tracker's reported lastX/lastY can be checked against a known position.

Parameters:
- H_ACTIVE, 160, active pixels per line (1..256)
- V_ACTIVE, 120, active lines per frame (1..256)
- H_BLANK, 16, clocks of href low after each line's active part (>=1)
- PIX_DIV, 2, clocks per pixel (>=1)
- VSYNC_LINES, 3, line periods with vsync high
- V_BACK, 2, blank line periods between vsync fall and first active line
- V_FRONT, 2, blank line periods after last active line

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run frames while high
- markerX  in  8  marker column, sampled at frame start
- markerY  in  8  marker row, sampled at frame start
- markerRed/markerGreen/markerBlue  in  8 each  marker colour, sampled at frame start
- vsync  out  1  frame sync, high during the VSYNC state
- href  out  1  high during the active part of each active line
- pixelReady  out  1  one-clock strobe per pixel, data valid
- outRed/outGreen/outBlue  out  8 each  pixel data
- frameCount  out  8  completed frames, wraps at 256

Behaviour:
- LINE_CLKS = H_ACTIVE*PIX_DIV + H_BLANK. Every vertical state counts in whole line periods.
- Reset (asynchronous, takes effect mid-frame immediately): state IDLE; all outputs 0; frameCount 0; all counters 0.
- FSM transitions:
  - IDLE -> VSYNC when enable=1 at a clock edge. vsync=1 on the next cycle.
  - VSYNC (VSYNC_LINES*LINE_CLKS clocks) -> VBACK.
  - VBACK (V_BACK*LINE_CLKS clocks) -> ACTIVE.
  - ACTIVE: V_ACTIVE lines. Per line, href=1 for H_ACTIVE*PIX_DIV clocks, then href=0 for H_BLANK clocks. After the last line -> VFRONT.
  - VFRONT (V_FRONT*LINE_CLKS clocks) -> VSYNC if enable=1 on its last cycle, else IDLE.
  - Any count of 0 skips that state.
- Marker registers: loaded on the IDLE->VSYNC and VFRONT->VSYNC transitions only. Input changes mid-frame have no effect until the next frame.
- Pixel counting:
  - pixDiv counts 0..PIX_DIV-1 while href=1.
  - x = pixel column, 0..H_ACTIVE-1; y = line number, 0..V_ACTIVE-1.
  - pixelReady=1 on the cycle where pixDiv==PIX_DIV-1 and href=1. With PIX_DIV=1 it is high for the whole of href.
- Pixel data:
  - While href=1, RGB is held constant for the whole pixel period.
  - At (x==markerX && y==markerY): RGB = marker colour.
  - Elsewhere: outRed=x, outGreen=y, outBlue=0.
  - href=0: RGB=0.
  - Marker outside the active area: no pixel is marked; this is not an error.
- frameCount increments (mod 256) on the last cycle of VFRONT.
- enable dropped mid-frame: the current frame completes, then the FSM goes to IDLE. Outputs stay low in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- x/y arithmetic is 8-bit. The H_ACTIVE/V_ACTIVE ranges guarantee no wrap.

Decomposition:
- Shared package/include holds:
  - FSM state encodings (IDLE, VSYNC, VBACK, ACTIVE, VFRONT)
  - the pixel width constant (8)
  - the LINE_CLKS derivation
- One natural sub-module, camera_line_timer: the horizontal clock/pixel counter.
  - Outputs href, pixelReady, x and an endOfLine pulse.
  - Gated by a lineRun input from the FSM.

Test Plan (small parameters unless stated: H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, PIX_DIV=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1; LINE_CLKS=10, frame=60 clocks):
- Reset release with enable=1 -> vsync high for exactly 10 clocks starting the cycle after the first enabled edge; first href rise 10 clocks after vsync fall; href high 8 clocks, low 2, three times; frame repeats every 60 clocks.
- PIX_DIV=2 -> 4 pixelReady pulses per line, 2 clocks apart, each one clock wide, coincident with the second clock of each pixel; PIX_DIV=1 -> pixelReady equals href.
- markerX=2, markerY=1, marker=(200,10,30) -> exactly one pixelReady sample carries (200,10,30), on line 1, column 2; pixel (3,2) carries (3,2,0).
- Change markerX from 2 to 0 during line 0 -> current frame still marks column 2; next frame marks column 0.
- Deassert enable mid-frame -> frame completes, frameCount increments by 1, then vsync/href stay 0; reassert -> vsync on the next cycle.
- Assert reset mid-line -> all outputs 0 the same cycle with no clock edge needed; frameCount 0; run 256 frames -> frameCount wraps to 0.
